gmii_tx_arbiter: RTL and testbench
==================================

# gmii_tx_arbiter

Shares one GMII transmit port between two byte-stream frame sources: port 0 carries PTP event frames, port 1 carries general traffic. Each frame is wrapped in preamble and SFD and followed by a guaranteed inter-frame gap. A start-of-frame strobe is emitted for the timestamp unit. The block sits between the frame builders and the GMII TX pins. It is the synthesizable transmit-side counterpart to the RX stimulus used in the top-level bench.

## Interface
- IFG_CYCLES, 12, idle cycles (gmii_txctrl low) between frames; legal range 1..255
- PRE_CYCLES, 7, number of 0x55 preamble bytes before the SFD; legal range 1..15
- PRIO_MODE, 1, 1 = strict priority to port 0; 0 = round-robin

Ports:
- gmii_txclk  in  1  125 MHz GMII transmit clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- src0_valid  in  1  port 0 byte valid
- src0_data  in  8  port 0 frame byte
- src0_last  in  1  port 0 final byte of frame
- src0_ready  out  1  port 0 byte accepted when high with src0_valid
- src1_valid / src1_data / src1_last / src1_ready: same as port 0, for port 1
- gmii_txctrl  out  1  GMII TX_EN
- gmii_txerr  out  1  GMII TX_ER
- gmii_txdata  out  8  GMII TXD
- tx_sof  out  1  one-cycle strobe coincident with the first frame byte on gmii_txdata
- tx_sof_port  out  1  port that owns the frame flagged by tx_sof
- tx_busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, PRE, SFD, DATA, IFG. Register `grant` (1 bit) selects the active port; register `last_grant` records the previous winner.
- IDLE: arbitrate whenever either srcN_valid is high.
  - PRIO_MODE=1: port 0 wins whenever src0_valid is high.
  - PRIO_MODE=0: with a single requester, that port wins. With both requesting, the port ≠ last_grant wins.
  - On a win: latch grant, set last_grant = grant, go to PRE with counter = PRE_CYCLES.
- PRE: drive 0x55 with ctrl=1. Decrement the counter; when it reaches 1, go to SFD.
- SFD: drive 0xD5 with ctrl=1. Go to DATA.
- Ready is combinational: srcN_ready = (grant==N) & (state==SFD | state==DATA). A port that is not granted never sees ready.
- Accepted byte (valid & ready): appears on gmii_txdata on the next clock edge with ctrl=1.
  - The first accepted byte of the frame also sets tx_sof=1 and tx_sof_port=grant for that one cycle.
  - If the accepted byte has last=1, go to IFG with counter = IFG_CYCLES.
- Underrun: any cycle with ready=1 and valid=0.
  - Next edge drives ctrl=1, err=1, data=0x00 for one cycle, then goes to IFG.
  - The source must then discard the remainder of its frame; the block does not consume it.
- IFG: drive ctrl=0, err=0, data=0x00. Decrement the counter; when it reaches 1, go to IDLE.
- Requests raised during PRE/SFD/DATA/IFG wait; arbitration happens only in IDLE.
- Zero-length frames are not supported; a frame is always at least one byte.

## Timing
- All GMII outputs, tx_sof, tx_sof_port and tx_busy are registered. srcN_ready is the only combinational output.
- Reset values: gmii_txctrl=0, gmii_txerr=0, gmii_txdata=0x00, tx_sof=0, tx_sof_port=0, tx_busy=0, state=IDLE, grant=0, last_grant=1. With last_grant=1, port 0 wins the first contended round-robin.
- Request-to-wire latency: valid first seen high in IDLE at cycle k.
  - Preamble is on the wire for cycles k+1..k+PRE_CYCLES.
  - SFD is on the wire at k+PRE_CYCLES+1.
  - The first frame byte is on the wire at k+PRE_CYCLES+2 (k+9 with defaults).
- Byte throughput: one byte per cycle, with no bubbles while the source keeps valid high.
- Gap: gmii_txctrl is low for exactly IFG_CYCLES cycles between the last byte of a frame and the first preamble byte of a back-to-back frame.
- Reset asserted mid-frame: outputs clear asynchronously, the frame is truncated without err, and the FSM returns to IDLE.
- src_last and underrun are never simultaneous, since underrun requires valid=0.

## Test plan
- Single port-0 frame of 4 bytes {0x01,0x02,0x03,0x04}:
  - wire shows 7×0x55, 0xD5, then 01 02 03 04 with ctrl=1, followed by 12 cycles of ctrl=0;
  - tx_sof is high only on the 0x01 cycle, with tx_sof_port=0.
- PRIO_MODE=1, both ports continuously valid with 3 frames each: all port-0 frames go out before any port-1 frame; each gap is exactly 12 idle cycles.
- PRIO_MODE=0, both ports continuously valid: frames alternate 0,1,0,1 starting with port 0; tx_sof_port toggles with each frame.
- Underrun: port 1 drops valid on the third data cycle:
  - wire shows two data bytes, then one cycle of ctrl=1, err=1, data=0x00;
  - followed by 12 idle cycles, then return to IDLE.
- Reset pulse during the DATA state: gmii_txctrl falls within the same cycle, without waiting for a clock edge; all outputs equal their reset values; the next request restarts with a full preamble.
- IFG_CYCLES=1, PRE_CYCLES=1: back-to-back 1-byte frames give the repeating pattern 55 D5 xx followed by a single idle cycle.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: shares one GMII TX port between a PTP event source (port 0)
// and a general traffic source (port 1). Each frame is wrapped in preamble and
// SFD and followed by a guaranteed inter-frame gap. tx_sof marks the first
// frame byte on the wire so the timestamp unit can capture it.
//
// state | meaning
// IDLE  | wire idle, arbitrating between pending sources
// PRE   | driving 0x55 preamble bytes, cnt counts down the remaining ones
// SFD   | driving 0xD5; granted source is offered ready for its first byte
// DATA  | forwarding frame bytes; ready held high to the granted source
// IFG   | wire idle for the inter-frame gap, cnt counts down
module gmii_tx_arbiter #(
   parameter int IFG_CYCLES = 12,
   parameter int PRE_CYCLES = 7,
   parameter int PRIO_MODE  = 1
) (
   input  logic       gmii_txclk,
   input  logic       rst,
   input  logic       src0_valid,
   input  logic [7:0] src0_data,
   input  logic       src0_last,
   output logic       src0_ready,
   input  logic       src1_valid,
   input  logic [7:0] src1_data,
   input  logic       src1_last,
   output logic       src1_ready,
   output logic       gmii_txctrl,
   output logic       gmii_txerr,
   output logic [7:0] gmii_txdata,
   output logic       tx_sof,
   output logic       tx_sof_port,
   output logic       tx_busy
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_IFG} state_t;

   state_t     state;
   logic       grant;
   logic       last_grant;
   logic [7:0] cnt;
   logic       win;
   logic       in_xfer;
   logic       sel_valid;
   logic       sel_last;
   logic [7:0] sel_data;

   // Arbitration winner, evaluated only when the FSM is in IDLE.
   always_comb begin
      win = 1'b0;
      if (PRIO_MODE != 0)
         win = ~src0_valid;
      else if (src0_valid && src1_valid)
         win = ~last_grant;
      else
         win = ~src0_valid;
   end

   assign in_xfer    = (state == S_SFD) || (state == S_DATA);
   assign src0_ready = ~grant & in_xfer;
   assign src1_ready = grant & in_xfer;
   assign sel_valid  = grant ? src1_valid : src0_valid;
   assign sel_last   = grant ? src1_last  : src0_last;
   assign sel_data   = grant ? src1_data  : src0_data;

   // Framing FSM; every wire-facing output is registered alongside the state.
   always_ff @(posedge gmii_txclk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         cnt         <= 8'd0;
         gmii_txctrl <= 1'b0;
         gmii_txerr  <= 1'b0;
         gmii_txdata <= 8'h00;
         tx_sof      <= 1'b0;
         tx_sof_port <= 1'b0;
         tx_busy     <= 1'b0;
      end else begin
         tx_sof <= 1'b0;
         case (state)
            S_IDLE: begin
               gmii_txerr <= 1'b0;
               if (src0_valid || src1_valid) begin
                  grant       <= win;
                  last_grant  <= win;
                  cnt         <= 8'(PRE_CYCLES);
                  state       <= S_PRE;
                  gmii_txctrl <= 1'b1;
                  gmii_txdata <= 8'h55;
                  tx_busy     <= 1'b1;
               end else begin
                  gmii_txctrl <= 1'b0;
                  gmii_txdata <= 8'h00;
                  tx_busy     <= 1'b0;
               end
            end
            S_PRE: begin
               gmii_txctrl <= 1'b1;
               gmii_txerr  <= 1'b0;
               tx_busy     <= 1'b1;
               if (cnt == 8'd1) begin
                  state       <= S_SFD;
                  gmii_txdata <= 8'hD5;
               end else begin
                  cnt         <= cnt - 8'd1;
                  gmii_txdata <= 8'h55;
               end
            end
            S_SFD, S_DATA: begin
               gmii_txctrl <= 1'b1;
               tx_busy     <= 1'b1;
               if (sel_valid) begin
                  gmii_txerr  <= 1'b0;
                  gmii_txdata <= sel_data;
                  if (state == S_SFD) begin
                     tx_sof      <= 1'b1;
                     tx_sof_port <= grant;
                  end
                  if (sel_last) begin
                     state <= S_IFG;
                     cnt   <= 8'(IFG_CYCLES);
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  // Source starved mid-frame: poison the frame and close it out.
                  gmii_txerr  <= 1'b1;
                  gmii_txdata <= 8'h00;
                  state       <= S_IFG;
                  cnt         <= 8'(IFG_CYCLES);
               end
            end
            S_IFG: begin
               gmii_txctrl <= 1'b0;
               gmii_txerr  <= 1'b0;
               gmii_txdata <= 8'h00;
               if (cnt == 8'd1) begin
                  state   <= S_IDLE;
                  tx_busy <= 1'b0;
               end else begin
                  cnt     <= cnt - 8'd1;
                  tx_busy <= 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               gmii_txctrl <= 1'b0;
               gmii_txerr  <= 1'b0;
               gmii_txdata <= 8'h00;
               tx_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: three instances (defaults, round-robin, short
// preamble/gap). Sources are fed from byte queues; the expected wire stream
// is built from frame lists by a frame-level model.
module tb_gmii_tx_arbiter;

   typedef struct packed {
      logic       ctrl;
      logic       err;
      logic [7:0] data;
      logic       sof;
      logic       port;
      logic       busy;
      logic       rdy0;
      logic       rdy1;
   } smp_t;

   logic       clk;
   logic       rst;
   logic       sv0 [3];
   logic       sv1 [3];
   logic       sl0 [3];
   logic       sl1 [3];
   logic [7:0] sd0 [3];
   logic [7:0] sd1 [3];
   logic       sr0 [3];
   logic       sr1 [3];
   logic       oc [3];
   logic       oe [3];
   logic [7:0] od [3];
   logic       osof [3];
   logic       oport [3];
   logic       obusy [3];

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] m0[$];
   logic [8:0] m1[$];
   smp_t       exp_q[$];
   int         cur;
   int         n_pass;
   int         n_total;

   gmii_tx_arbiter #(.IFG_CYCLES(12), .PRE_CYCLES(7), .PRIO_MODE(1)) dut_prio (
      .gmii_txclk(clk), .rst(rst),
      .src0_valid(sv0[0]), .src0_data(sd0[0]), .src0_last(sl0[0]), .src0_ready(sr0[0]),
      .src1_valid(sv1[0]), .src1_data(sd1[0]), .src1_last(sl1[0]), .src1_ready(sr1[0]),
      .gmii_txctrl(oc[0]), .gmii_txerr(oe[0]), .gmii_txdata(od[0]),
      .tx_sof(osof[0]), .tx_sof_port(oport[0]), .tx_busy(obusy[0]));

   gmii_tx_arbiter #(.IFG_CYCLES(12), .PRE_CYCLES(7), .PRIO_MODE(0)) dut_rr (
      .gmii_txclk(clk), .rst(rst),
      .src0_valid(sv0[1]), .src0_data(sd0[1]), .src0_last(sl0[1]), .src0_ready(sr0[1]),
      .src1_valid(sv1[1]), .src1_data(sd1[1]), .src1_last(sl1[1]), .src1_ready(sr1[1]),
      .gmii_txctrl(oc[1]), .gmii_txerr(oe[1]), .gmii_txdata(od[1]),
      .tx_sof(osof[1]), .tx_sof_port(oport[1]), .tx_busy(obusy[1]));

   gmii_tx_arbiter #(.IFG_CYCLES(1), .PRE_CYCLES(1), .PRIO_MODE(1)) dut_short (
      .gmii_txclk(clk), .rst(rst),
      .src0_valid(sv0[2]), .src0_data(sd0[2]), .src0_last(sl0[2]), .src0_ready(sr0[2]),
      .src1_valid(sv1[2]), .src1_data(sd1[2]), .src1_last(sl1[2]), .src1_ready(sr1[2]),
      .gmii_txctrl(oc[2]), .gmii_txerr(oe[2]), .gmii_txdata(od[2]),
      .tx_sof(osof[2]), .tx_sof_port(oport[2]), .tx_busy(obusy[2]));

   initial clk = 1'b0;
   always #4 clk = ~clk;

   function automatic smp_t mk(logic c, logic e, logic [7:0] d, logic s, logic p,
                               logic b, logic r0, logic r1);
      smp_t x;
      x = '{ctrl: c, err: e, data: d, sof: s, port: p, busy: b, rdy0: r0, rdy1: r1};
      return x;
   endfunction

   function automatic smp_t sample(int d);
      return mk(oc[d], oe[d], od[d], osof[d], oport[d], obusy[d], sr0[d], sr1[d]);
   endfunction

   // tx_sof_port only carries meaning on the tx_sof cycle.
   function automatic smp_t mask(smp_t s);
      smp_t x;
      x = s;
      if (!x.sof) x.port = 1'b0;
      return x;
   endfunction

   function automatic string fmt(smp_t s);
      return $sformatf("ctrl=%b err=%b data=%02h sof=%b port=%b busy=%b rdy=%b%b",
                       s.ctrl, s.err, s.data, s.sof, s.port, s.busy, s.rdy0, s.rdy1);
   endfunction

   // Present the head of each port queue to the currently selected instance.
   task automatic refresh();
      for (int d = 0; d < 3; d++) begin
         sv0[d] = 1'b0; sl0[d] = 1'b0; sd0[d] = 8'h00;
         sv1[d] = 1'b0; sl1[d] = 1'b0; sd1[d] = 8'h00;
      end
      if (q0.size() > 0) begin
         sv0[cur] = 1'b1; sd0[cur] = q0[0][7:0]; sl0[cur] = q0[0][8];
      end
      if (q1.size() > 0) begin
         sv1[cur] = 1'b1; sd1[cur] = q1[0][7:0]; sl1[cur] = q1[0][8];
      end
   endtask

   // Source driver: handshake sampled mid-cycle, queue advanced after the edge.
   initial begin
      logic a0, a1;
      forever begin
         @(negedge clk);
         a0 = sv0[cur] & sr0[cur];
         a1 = sv1[cur] & sr1[cur];
         @(posedge clk);
         #1;
         if (a0 && q0.size() > 0) void'(q0.pop_front());
         if (a1 && q1.size() > 0) void'(q1.pop_front());
         refresh();
      end
   end

   task automatic push_byte(input int port, input logic [7:0] d, input logic last);
      if (port == 0) begin
         q0.push_back({last, d}); m0.push_back({last, d});
      end else begin
         q1.push_back({last, d}); m1.push_back({last, d});
      end
   endtask

   task automatic add_frame(input int port, input int len, input bit underrun);
      logic [31:0] r;
      for (int j = 0; j < len; j++) begin
         r = $urandom;
         push_byte(port, r[7:0], (j == len - 1) && !underrun);
      end
   endtask

   // Frame-level model: pick frame order by the arbitration rule, then lay out
   // preamble, SFD, payload (or error byte on starvation) and the gap.
   function automatic void build_model(int pre, int ifg, int prio);
      logic       lg;
      logic       g;
      logic [8:0] b;
      logic       first;
      lg = 1'b1;
      exp_q.delete();
      exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
      while (m0.size() > 0 || m1.size() > 0) begin
         if (prio != 0) g = (m0.size() == 0);
         else if (m0.size() > 0 && m1.size() > 0) g = ~lg;
         else g = (m0.size() == 0);
         lg = g;
         repeat (pre) exp_q.push_back(mk(1, 0, 8'h55, 0, 0, 1, 0, 0));
         exp_q.push_back(mk(1, 0, 8'hD5, 0, 0, 1, ~g, g));
         first = 1'b1;
         while (1) begin
            b = g ? m1.pop_front() : m0.pop_front();
            exp_q.push_back(mk(1, 0, b[7:0], first, g, 1, ~g & ~b[8], g & ~b[8]));
            first = 1'b0;
            if (b[8]) break;
            if ((g ? m1.size() : m0.size()) == 0) begin
               exp_q.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 0));
               break;
            end
         end
         for (int i = 1; i <= ifg; i++) exp_q.push_back(mk(0, 0, 8'h00, 0, 0, i < ifg, 0, 0));
      end
      repeat (3) exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      q0.delete(); q1.delete(); m0.delete(); m1.delete();
      refresh();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      smp_t got;
      apply_reset();
      for (int d = 0; d < 3; d++) begin
         got = sample(d);
         n_total++;
         if (got !== mk(0, 0, 8'h00, 0, 0, 0, 0, 0))
            $display("FAIL reset_values dut%0d: got %s want all zero", d, fmt(got));
         else n_pass++;
      end
   endtask

   task automatic test_single_frame();
      smp_t got;
      apply_reset();
      cur = 0;
      push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 0);
      push_byte(0, 8'h03, 0); push_byte(0, 8'h04, 1);
      build_model(7, 12, 1);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL single_frame cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      smp_t got;
      apply_reset();
      cur = 0;
      for (int f = 0; f < 3; f++) begin
         add_frame(0, int'($urandom_range(1, 5)), 0);
         add_frame(1, int'($urandom_range(1, 5)), 0);
      end
      build_model(7, 12, 1);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL priority cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      smp_t got;
      apply_reset();
      cur = 1;
      for (int f = 0; f < 3; f++) begin
         add_frame(0, int'($urandom_range(1, 5)), 0);
         add_frame(1, int'($urandom_range(1, 5)), 0);
      end
      add_frame(1, int'($urandom_range(1, 4)), 0);
      build_model(7, 12, 0);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL round_robin cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   task automatic test_underrun();
      smp_t got;
      apply_reset();
      cur = 0;
      add_frame(1, 2, 1);
      build_model(7, 12, 1);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL underrun cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      smp_t       got;
      logic [7:0] third;
      apply_reset();
      cur = 0;
      add_frame(0, 10, 0);
      third = m0[2][7:0];
      refresh();
      repeat (11) @(posedge clk);
      #2;
      n_total++;
      if (oc[0] !== 1'b1 || obusy[0] !== 1'b1 || od[0] !== third)
         $display("FAIL mid_frame_data: got ctrl=%b busy=%b data=%02h want ctrl=1 busy=1 data=%02h",
                  oc[0], obusy[0], od[0], third);
      else n_pass++;
      rst = 1'b1;
      #1;
      got = sample(0);
      n_total++;
      if (got !== mk(0, 0, 8'h00, 0, 0, 0, 0, 0))
         $display("FAIL async_reset_clear: got %s want all zero", fmt(got));
      else n_pass++;
      q0.delete(); m0.delete();
      refresh();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      add_frame(0, 3, 0);
      build_model(7, 12, 1);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL restart cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back_short();
      smp_t got;
      apply_reset();
      cur = 2;
      for (int f = 0; f < 4; f++) add_frame(0, 1, 0);
      add_frame(1, 1, 0);
      build_model(1, 1, 1);
      refresh();
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = sample(cur);
         n_total++;
         if (mask(got) !== mask(exp_q[i]))
            $display("FAIL short_gap cyc %0d: got %s want %s", i, fmt(got), fmt(exp_q[i]));
         else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      cur     = 0;
      rst     = 1'b1;
      refresh();
      test_reset();
      test_single_frame();
      test_priority();
      test_round_robin();
      test_underrun();
      test_reset_mid_frame();
      test_back_to_back_short();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
